reg_initiator: RTL and testbench

Register-bus initiator: the requesting end of the `req`/`ack` register protocol served by the `regs` block. It accepts single read or write commands from a host-side valid/ready interface and drives `req`, `addr`, `rd_wr` and `write_val` toward the register block. It then waits for `ack`, captures `read_val` on reads, and returns one response per command. A programmable timeout converts a missing `ack` into an error response, so a dead target cannot hang the host.

---
 rtl/reg_pkg.sv | 23 ++
 rtl/reg_timeout_cnt.sv | 45 ++++
 rtl/reg_initiator.sv | 121 ++++++++++++
 tb/tb_reg_initiator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared definitions for the req/ack register-bus initiator and its helpers.
package reg_pkg;

  localparam logic REG_RD = 1'b1;
  localparam logic REG_WR = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } reg_state_e;

  // Debug-only status; stray_ack records an ack seen with no request outstanding.
  typedef struct packed {
    logic stray_ack;
  } reg_dbg_t;

  // A disabled timeout (0) still gets a 1-bit counter so the vector stays legal.
  function automatic int tmo_cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/reg_timeout_cnt.sv
// Saturating clear/enable cycle counter; hit flags the last allowed cycle of a request.
// Clear wins over enable; hit is constant 0 when TIMEOUT_P is 0.
module reg_timeout_cnt
  import reg_pkg::*;
#(
  parameter int TIMEOUT_P = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int CW = tmo_cnt_width(TIMEOUT_P);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (TIMEOUT_P == 0) begin : g_off
      assign hit_o = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_P - 1);
      assign hit_o = en_i && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/reg_initiator.sv
// Register-bus initiator: one host command -> one req/ack bus transaction -> one response.
// Every output comes straight from a register; cmd_ready stays low until the response is taken.
module reg_initiator
  import reg_pkg::*;
#(
  parameter int ADDR_SIZE_P = 4,
  parameter int TIMEOUT_P   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rd_wr,
  input  logic [ADDR_SIZE_P-1:0] cmd_addr,
  input  logic [31:0]            cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   req,
  output logic [ADDR_SIZE_P-1:0] addr,
  output logic                   rd_wr,
  output logic [31:0]            write_val,
  input  logic [31:0]            read_val,
  input  logic                   ack
);

  reg_state_e             state_q, state_d;
  logic [ADDR_SIZE_P-1:0] addr_q, addr_d;
  logic                   rd_wr_q, rd_wr_d;
  logic [31:0]            write_val_q, write_val_d;
  logic [31:0]            rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  reg_dbg_t               dbg_q, dbg_d;
  logic                   accept;
  logic                   tmo_hit;

  assign accept = (state_q == IDLE) && cmd_valid;

  reg_timeout_cnt #(
    .TIMEOUT_P(TIMEOUT_P)
  ) u_tmo (
    .clk  (clk),
    .reset(reset),
    .clr_i(accept),
    .en_i (state_q == REQ),
    .hit_o(tmo_hit)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rd_wr_d         = rd_wr_q;
    write_val_d     = write_val_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_err_d       = rsp_err_q;
    dbg_d           = dbg_q;
    dbg_d.stray_ack = dbg_q.stray_ack | (ack && (state_q != REQ));

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          rd_wr_d     = cmd_rd_wr;
          write_val_d = (cmd_rd_wr == REG_WR) ? cmd_wdata : '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // An ack arriving on the timeout cycle still completes normally.
        if (ack) begin
          rsp_rdata_d = (rd_wr_q == REG_RD) ? read_val : '0;
          rsp_err_d   = 1'b0;
          state_d     = RSP;
        end else if (tmo_hit) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_wr_q     <= 1'b0;
      write_val_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      dbg_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_wr_q     <= rd_wr_d;
      write_val_q <= write_val_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      dbg_q       <= dbg_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign req       = (state_q == REQ);
  assign rsp_valid = (state_q == RSP);
  assign addr      = addr_q;
  assign rd_wr     = rd_wr_q;
  assign write_val = write_val_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_reg_initiator.sv
// Randomized scoreboard bench for reg_initiator with a memory-backed register target.
module tb_reg_initiator;

  localparam int AW    = 4;
  localparam int TMO   = 4;
  localparam int NOACK = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_rd_wr;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          req, rd_wr, ack;
  logic [AW-1:0] addr;
  logic [31:0]   write_val, read_val;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  // k = index of the req cycle in which the target acks (k >= TMO means never).
  typedef struct {
    int          k;
    int          len;
    bit          known;
    logic        rd;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
    logic        rsp;
  } plan_t;

  rsp_t  exp_q[$];
  plan_t plan_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] tgt_mem [16];
  int checks = 0;
  int errors = 0;
  int bp_left = 0;
  bit stray_req = 0;

  always #5 clk = ~clk;

  reg_initiator #(
    .ADDR_SIZE_P(AW),
    .TIMEOUT_P  (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rd_wr(cmd_rd_wr),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .req      (req),
    .addr     (addr),
    .rd_wr    (rd_wr),
    .write_val(write_val),
    .read_val (read_val),
    .ack      (ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_req", 32'(req), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_rd_wr", 32'(rd_wr), 0);
    chk("rst_write_val", write_val, 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_stray_ack", 32'(dut.dbg_q.stray_ack), 0);
  endtask

  // Expected outcome comes from the protocol rules: ack within TMO req cycles
  // completes (reads return the register contents), otherwise an error with data 0.
  task automatic issue(input logic rd, input logic [AW-1:0] a, input logic [31:0] wd,
                       input int k, input bit no_rsp);
    plan_t p;
    rsp_t  r;
    int    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", 32'(n), 0);
      return;
    end
    p.k     = k;
    p.len   = no_rsp ? -1 : ((k < TMO) ? k + 1 : TMO);
    p.known = 1'b1;
    p.rd    = rd;
    p.addr  = a;
    p.wdata = rd ? 32'h0 : wd;
    p.rsp   = !no_rsp;
    if (!no_rsp) begin
      r.err   = (k >= TMO);
      r.rdata = (rd && k < TMO) ? ref_mem[a] : 32'h0;
      if (!rd && k < TMO) ref_mem[a] = wd;
      exp_q.push_back(r);
    end
    plan_q.push_back(p);
    cmd_valid = 1'b1;
    cmd_rd_wr = rd;
    cmd_addr  = a;
    cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_wait_timeout", 32'(n), 0);
  endtask

  // Stimulus
  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_rd_wr = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset_values();

    issue(1'b0, 4'h0, 32'h0000_0013, 0, 1'b0);
    wait_idle();
    issue(1'b0, 4'h0, 32'h0000_0031, 0, 1'b0);
    issue(1'b1, 4'h0, 32'hDEAD_BEEF, 3, 1'b0);
    wait_idle();

    issue(1'b1, 4'h0, 32'h0, NOACK, 1'b0);
    issue(1'b0, 4'h7, 32'hA5A5_0001, 1, 1'b0);
    wait_idle();

    bp_left = 5;
    issue(1'b1, 4'h0, 32'h0, 1, 1'b0);
    wait_idle();

    chk("stray_before", 32'(dut.dbg_q.stray_ack), 0);
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("stray_after", 32'(dut.dbg_q.stray_ack), 1);
    chk("stray_no_rsp", 32'(rsp_valid), 0);
    chk("stray_cmd_ready", 32'(cmd_ready), 1);

    issue(1'b0, 4'h2, 32'h1234_5678, TMO - 1, 1'b0);
    wait_idle();
    issue(1'b1, 4'h2, 32'h0, TMO - 1, 1'b0);
    wait_idle();

    issue(1'b1, 4'h3, 32'h0, NOACK, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_values();

    for (int t = 0; t < 150; t++) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, TMO + 1), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    chk("plan_q_drained", 32'(plan_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Register target: acks in the planned req cycle and checks the bus fields.
  initial begin
    bit    in_req = 1'b0;
    int    cnt = 0;
    plan_t p;
    ack = 1'b0;
    read_val = '0;
    foreach (tgt_mem[i]) tgt_mem[i] = 32'h0;
    p.k = -1; p.len = -1; p.known = 1'b0; p.rd = 1'b0; p.addr = '0; p.wdata = '0; p.rsp = 1'b0;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      read_val = $urandom;
      if (req) begin
        if (!in_req) begin
          in_req = 1'b1;
          cnt = 0;
          if (plan_q.size() == 0) begin
            chk("req_without_cmd", 32'(req), 0);
            p.k = -1; p.len = -1; p.known = 1'b0; p.rsp = 1'b0;
          end else begin
            p = plan_q.pop_front();
          end
        end
        if (p.known) begin
          chk("bus_addr", 32'(addr), 32'(p.addr));
          chk("bus_rd_wr", 32'(rd_wr), 32'(p.rd));
          chk("bus_write_val", write_val, p.wdata);
        end
        chk("cmd_ready_in_req", 32'(cmd_ready), 0);
        if (cnt == p.k) begin
          ack = 1'b1;
          if (rd_wr) read_val = tgt_mem[addr];
          else tgt_mem[addr] = write_val;
        end
        cnt++;
      end else if (in_req) begin
        in_req = 1'b0;
        if (p.len >= 0) chk("req_cycles", 32'(cnt), 32'(p.len));
        chk("rsp_after_req", 32'(rsp_valid), 32'(p.rsp));
      end
      if (stray_req) begin
        ack = 1'b1;
        stray_req = 1'b0;
      end
    end
  end

  // Response monitor: drives rsp_ready, checks hold-stability and pops the scoreboard.
  initial begin
    bit          held = 1'b0;
    logic [31:0] h_rdata = '0;
    logic        h_err = 1'b0;
    bit          rdy;
    rsp_t        e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (held) begin
          chk("rsp_rdata_stable", rsp_rdata, h_rdata);
          chk("rsp_err_stable", 32'(rsp_err), 32'(h_err));
        end
        if (bp_left > 0) begin
          rdy = 1'b0;
          bp_left--;
          chk("bp_cmd_ready", 32'(cmd_ready), 0);
          chk("bp_req", 32'(req), 0);
        end else begin
          rdy = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = rdy;
        if (rdy) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
          end
        end else begin
          held = 1'b1;
          h_rdata = rsp_rdata;
          h_err = rsp_err;
        end
      end else begin
        held = 1'b0;
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

endmodule
